// File: rtl/mem_arbiter.sv
// Byte-serial sequencer sharing the 8-bit RAM/IO bus between instruction fetch and MEM.
// Each granted transaction is expanded into 1/2/4 bus beats; read bytes assemble little-endian.
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              mem_req,
   input  logic              mem_wr_en,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_len,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

   state_t            state_q, state_d;
   logic              owner_if_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        len_m1_q;
   logic [31:0]       wdata_q;
   logic [2:0]        beat_cnt_q;
   logic [2:0]        cap_cnt_q;
   logic              pend_q;
   logic [31:0]       data_q;
   logic              wr_reg;
   logic [ADDR_W-1:0] ram_a_q;
   logic [7:0]        ram_dout_q;
   logic [31:0]       if_data_q;
   logic [31:0]       mem_rdata_q;

   logic        grant;
   logic        beat_fire;
   logic        last_beat;
   logic        cap_last;
   logic        flush_cancel;
   logic [1:0]  len_sel;
   logic [2:0]  len_full;
   logic [2:0]  next_beat;
   logic [31:0] data_next;

   assign len_full     = {1'b0, len_m1_q} + 3'd1;
   assign next_beat    = beat_cnt_q + 3'd1;
   assign grant        = (state_q == IDLE) && rdy && (mem_req || (if_req && !if_flush));
   assign len_sel      = mem_req ? (mem_len[1] ? 2'd3 : {1'b0, mem_len[0]}) : 2'd3;
   assign beat_fire    = rdy && ((state_q == READ) || (state_q == WRITE)) && (beat_cnt_q < len_full);
   assign last_beat    = (beat_cnt_q == {1'b0, len_m1_q});
   // Last byte is either being captured now or already captured while rdy was low.
   assign cap_last     = (pend_q && (cap_cnt_q == {1'b0, len_m1_q})) || (cap_cnt_q == len_full);
   assign flush_cancel = (state_q == READ) && owner_if_q && if_flush;

   always_comb begin
      data_next = data_q;
      if (pend_q) data_next[8*cap_cnt_q[1:0] +: 8] = ram_din;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (grant) state_d = (mem_req && mem_wr_en) ? WRITE : READ;
         READ: begin
            if (flush_cancel)          state_d = IDLE;
            else if (rdy && cap_last)  state_d = FINISH;
         end
         WRITE:  if (beat_fire && last_beat) state_d = FINISH;
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if_done   = (state_q == FINISH) && owner_if_q && !if_flush;
      mem_done  = (state_q == FINISH) && !owner_if_q;
      ram_wr    = wr_reg && rdy;
      busy      = (state_q != IDLE);
      ram_a     = ram_a_q;
      ram_dout  = ram_dout_q;
      if_data   = if_data_q;
      mem_rdata = mem_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_if_q  <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         len_m1_q    <= 2'd0;
         wdata_q     <= 32'd0;
         beat_cnt_q  <= 3'd0;
         cap_cnt_q   <= 3'd0;
         pend_q      <= 1'b0;
         data_q      <= 32'd0;
         wr_reg      <= 1'b0;
         ram_a_q     <= '0;
         ram_dout_q  <= 8'd0;
         if_data_q   <= 32'd0;
         mem_rdata_q <= 32'd0;
      end else if (grant) begin
         owner_if_q <= !mem_req;
         write_q    <= mem_req && mem_wr_en;
         addr_q     <= mem_req ? mem_addr : if_addr;
         len_m1_q   <= len_sel;
         wdata_q    <= mem_wdata;
         beat_cnt_q <= 3'd0;
         cap_cnt_q  <= 3'd0;
         pend_q     <= 1'b0;
         data_q     <= 32'd0;
         wr_reg     <= mem_req && mem_wr_en;
         ram_a_q    <= mem_req ? mem_addr : if_addr;
         if (mem_req && mem_wr_en) ram_dout_q <= mem_wdata[7:0];
      end else begin
         pend_q <= (state_q == READ) && beat_fire && !flush_cancel;
         if (beat_fire) begin
            beat_cnt_q <= next_beat;
            if (next_beat < len_full) begin
               ram_a_q <= addr_q + ADDR_W'(next_beat);
               if (write_q) ram_dout_q <= wdata_q[8*next_beat[1:0] +: 8];
            end else begin
               // Park the bus off the last address so an IO byte is never re-read.
               ram_a_q <= '0;
               wr_reg  <= 1'b0;
            end
         end
         if ((state_q == READ) && pend_q && !flush_cancel) begin
            data_q    <= data_next;
            cap_cnt_q <= cap_cnt_q + 3'd1;
         end
         if ((state_q == READ) && rdy && cap_last && !flush_cancel) begin
            if (owner_if_q) if_data_q   <= data_next;
            else            mem_rdata_q <= data_next;
         end
         if (flush_cancel) ram_a_q <= '0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural byte RAM, scoreboard queues for bus writes and
// completions, latency checks against the request cycle.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_done;
   logic [31:0] if_data;
   logic        mem_req;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [1:0]  mem_len;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic        busy;

   mem_arbiter dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_done(if_done), .if_data(if_data),
      .mem_req(mem_req), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_len(mem_len), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
      .ram_wr(ram_wr), .busy(busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural RAM ----------------
   logic [7:0] ram [logic [31:0]];

   always @(posedge clk) begin
      ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
      if (rst) begin
         ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
         ram[32'h200] = 8'h93; ram[32'h201] = 8'h00; ram[32'h202] = 8'h10; ram[32'h203] = 8'h00;
         ram[32'h30000] = 8'h41;
      end else if (ram_wr) begin
         ram[ram_a] = ram_dout;
      end
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [31:0] if_exp_q[$];
   logic [32:0] mem_exp_q[$];   // {is_load, rdata}
   logic [39:0] wr_exp_q[$];    // {addr, byte}
   logic [31:0] a_log [int];
   int io_reads = 0;
   int wr_cnt = 0;
   int stall_wr = 0;
   int if_done_cnt = 0;
   int mem_done_cnt = 0;

   always @(negedge clk) begin
      logic [39:0] we;
      logic [31:0] ie;
      logic [32:0] me;
      a_log[cyc] = ram_a;
      if (busy && rdy && !ram_wr && ram_a == 32'h30000) io_reads++;
      if (ram_wr) begin
         wr_cnt++;
         if (!rdy) stall_wr++;
         check("wr_q", 64'(wr_exp_q.size() != 0), 64'd1);
         if (wr_exp_q.size() != 0) begin
            we = wr_exp_q.pop_front();
            check("wr_beat", 64'({ram_a, ram_dout}), 64'(we));
         end
      end
      if (if_done) begin
         if_done_cnt++;
         check("if_q", 64'(if_exp_q.size() != 0), 64'd1);
         if (if_exp_q.size() != 0) begin
            ie = if_exp_q.pop_front();
            check("if_data", 64'(if_data), 64'(ie));
         end
      end
      if (mem_done) begin
         mem_done_cnt++;
         check("mem_q", 64'(mem_exp_q.size() != 0), 64'd1);
         if (mem_exp_q.size() != 0) begin
            me = mem_exp_q.pop_front();
            if (me[32]) check("mem_rdata", 64'(mem_rdata), 64'(me[31:0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Waits for a done pulse (bounded); returns at the start of cycle done+1.
   task automatic wait_done(input bit is_if, input int c0, input int exp_lat, input string tag);
      int lat;
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if ((is_if ? if_done : mem_done) === 1'b1) begin
            lat = cyc - c0;
            break;
         end
         tick();
      end
      check(tag, 64'(lat), 64'(exp_lat));
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ram_wr"},    64'(ram_wr),    64'd0);
      check({tag, "_ram_a"},     64'(ram_a),     64'd0);
      check({tag, "_ram_dout"},  64'(ram_dout),  64'd0);
      check({tag, "_busy"},      64'(busy),      64'd0);
      check({tag, "_if_done"},   64'(if_done),   64'd0);
      check({tag, "_mem_done"},  64'(mem_done),  64'd0);
      check({tag, "_if_data"},   64'(if_data),   64'd0);
      check({tag, "_mem_rdata"}, 64'(mem_rdata), 64'd0);
   endtask

   logic [1:0]  len_tab  [3] = '{2'b00, 2'b01, 2'b10};
   logic [31:0] addr_tab [3] = '{32'h40, 32'h20, 32'h60};
   int          n_tab    [3] = '{1, 2, 4};

   // ---------------- stimulus ----------------
   initial begin
      int c0, c4, lat, base, d0;
      logic [31:0] wd;
      rst = 1'b1; rdy = 1'b1;
      if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
      mem_req = 1'b0; mem_wr_en = 1'b0; mem_addr = 32'd0; mem_len = 2'b00; mem_wdata = 32'd0;
      repeat (3) tick();
      @(negedge clk);
      check_reset_outputs("rst");
      tick();
      rst = 1'b0;
      tick();

      // Fetch of 13 05 00 00 from 0x100.
      if_exp_q.push_back(32'h00000513);
      if_req = 1'b1; if_addr = 32'h100; c0 = cyc;
      wait_done(1'b1, c0, 6, "fetch_lat");
      if_req = 1'b0;
      for (int i = 0; i < 4; i++)
         check("fetch_a", 64'(a_log[c0 + 1 + i]), 64'(32'h100 + i));
      tick();

      // Byte / half / word stores.
      wd = 32'hAABBCCDD;
      for (int t = 0; t < 3; t++) begin
         for (int b = 0; b < n_tab[t]; b++)
            wr_exp_q.push_back({addr_tab[t] + 32'(b), wd[8*b +: 8]});
         mem_exp_q.push_back({1'b0, 32'h0});
         base = wr_cnt;
         mem_req = 1'b1; mem_wr_en = 1'b1; mem_addr = addr_tab[t];
         mem_len = len_tab[t]; mem_wdata = wd; c0 = cyc;
         wait_done(1'b0, c0, n_tab[t] + 1, "store_lat");
         mem_req = 1'b0; mem_wr_en = 1'b0;
         check("store_wr_cnt", 64'(wr_cnt - base), 64'(n_tab[t]));
         tick();
      end

      // Simultaneous requests: IO byte load wins, fetch follows.
      base = io_reads;
      mem_exp_q.push_back({1'b1, 32'h00000041});
      if_exp_q.push_back(32'h00100093);
      mem_req = 1'b1; mem_wr_en = 1'b0; mem_addr = 32'h30000; mem_len = 2'b00;
      if_req = 1'b1; if_addr = 32'h200; c0 = cyc;
      wait_done(1'b0, c0, 3, "both_mem_lat");
      mem_req = 1'b0;
      wait_done(1'b1, c0, 10, "both_if_lat");
      if_req = 1'b0;
      check("io_reads", 64'(io_reads - base), 64'd1);
      tick();

      // Word store to the IO region with rdy low for cycles 3..5.
      wd = 32'h11223344;
      for (int b = 0; b < 4; b++) wr_exp_q.push_back({32'h30004 + 32'(b), wd[8*b +: 8]});
      mem_exp_q.push_back({1'b0, 32'h0});
      base = stall_wr;
      mem_req = 1'b1; mem_wr_en = 1'b1; mem_addr = 32'h30004; mem_len = 2'b10; mem_wdata = wd;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         rdy = !(k >= 3 && k <= 5);
         @(negedge clk);
         if (mem_done) begin
            lat = k;
            break;
         end
      end
      check("stall_lat", 64'(lat), 64'd8);
      tick();
      mem_req = 1'b0; mem_wr_en = 1'b0; rdy = 1'b1;
      check("stall_wr", 64'(stall_wr - base), 64'd0);
      tick();

      // Flush in cycle 3 of a fetch, new fetch from 0x200 in cycle 4.
      if_exp_q.push_back(32'h00100093);
      d0 = if_done_cnt;
      if_req = 1'b1; if_addr = 32'h100; c0 = cyc;
      repeat (3) tick();
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0; if_addr = 32'h200;
      @(negedge clk);
      check("flush_busy", 64'(busy), 64'd0);
      c4 = c0 + 4;
      wait_done(1'b1, c4, 6, "refetch_lat");
      if_req = 1'b0;
      check("flush_done_cnt", 64'(if_done_cnt - d0), 64'd1);
      tick();

      // Reset during write beat 1.
      wd = 32'hDEADBEEF;
      wr_exp_q.push_back({32'h80, 8'hEF});
      wr_exp_q.push_back({32'h81, 8'hBE});
      d0 = mem_done_cnt;
      mem_req = 1'b1; mem_wr_en = 1'b1; mem_addr = 32'h80; mem_len = 2'b10; mem_wdata = wd;
      tick();
      tick();
      rst = 1'b1; mem_req = 1'b0; mem_wr_en = 1'b0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("abort");
      repeat (6) tick();
      check("abort_no_done", 64'(mem_done_cnt - d0), 64'd0);

      check("if_q_left",  64'(if_exp_q.size()),  64'd0);
      check("mem_q_left", 64'(mem_exp_q.size()), 64'd0);
      check("wr_q_left",  64'(wr_exp_q.size()),  64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial memory transaction sequencer that shares the single 8-bit RAM/IO bus between instruction fetch and the MEM stage. Each requester posts one whole transaction (address, length, direction), and the block expands it into per-byte bus beats. It assembles read bytes little-endian and returns a one-cycle done pulse. It sits between pc_reg/mem and the top-level mem_din/mem_dout/mem_a/mem_wr pins, handles the rdy pause, and lets IF cancel a fetch on redirect.

## Interface
Parameters:
- ADDR_W, 32, address width of requester and bus addresses.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  pause; low freezes the transaction.
- if_req  in  1  fetch request; held with stable if_addr until if_done or flush.
- if_addr  in  32  fetch address; always 4 bytes.
- if_flush  in  1  cancels an in-progress fetch.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word.
- mem_req  in  1  load/store request; held with stable inputs until mem_done.
- mem_wr_en  in  1  1 = store, 0 = load.
- mem_addr  in  32  load/store byte address.
- mem_len  in  2  00: 1 byte, 01: 2 bytes, 10/11: 4 bytes.
- mem_wdata  in  32  store data; byte i = bits [8i+7:8i].
- mem_done  out  1  one-cycle pulse; mem_rdata valid for a load.
- mem_rdata  out  32  load data, zero-extended; sign extension is done by mem.
- ram_din  in  8  bus read data, valid the cycle after an address beat.
- ram_dout  out  8  bus write data.
- ram_a  out  32  bus address.
- ram_wr  out  1  bus write strobe; equals wr_reg & rdy.
- busy  out  1  state != IDLE.

## Operation
- States:
  - IDLE: no transaction.
  - READ: issue address beats, capture bytes.
  - WRITE: issue write beats.
  - FINISH: done pulse; requests ignored.
- IDLE grant, only when rdy=1:
  - mem_req wins over if_req.
  - Latch owner, address, length L (1/2/4), direction and wdata.
  - Beat counter and capture counter cleared; assembled data cleared.
- Beat i presents address addr+i (mod 2^32).
  - WRITE beat also presents ram_dout = wdata byte i and wr_reg = 1.
- A beat counts only in a cycle with rdy=1. With rdy=0, beat counter, state and ram_a/ram_dout hold, and ram_wr is forced 0, so no byte is written twice.
- Read capture: a counted read beat sets pend. The next cycle ram_din goes into byte lane cap_cnt, regardless of rdy, and cap_cnt increments.
- READ → FINISH when byte L-1 is captured.
- WRITE → FINISH after beat L-1 counts; wr_reg clears on entry to FINISH.
- FINISH:
  - Owner's done = 1; data output is the assembled word, upper unused bytes 0.
  - Next state IDLE. if_data/mem_rdata hold until the next completion of the same owner.
- if_flush while the owner is IF in READ: go to IDLE next cycle, no if_done, pend and captured bytes discarded.
- if_flush in IDLE with if_req: no grant that cycle.
- if_done = done_if_reg & ~if_flush (combinational mask).
- if_flush is ignored while the owner is MEM.
- IO range (addr[17:16]==2'b11) gets no special treatment: only the requested bytes are ever read or written, each exactly once.

## Timing
- Reset values: state IDLE, ram_a 0, ram_dout 0, ram_wr 0, if_done 0, mem_done 0, if_data 0, mem_rdata 0, busy 0.
- Reset mid-transaction aborts immediately; ram_wr is 0 the following cycle and no done is issued.
- Request seen in cycle 0 with rdy held high:
  - Read: beats in cycles 1..L, captures in cycles 2..L+1, done in cycle L+2. 4-byte fetch done in cycle 6.
  - Write: beats in cycles 1..L, done in cycle L+1.
- Each rdy=0 cycle during a transaction extends latency by exactly one cycle.
- The next grant is possible in cycle done+1. A requester that keeps req high in that cycle is taken as a new request.
- if_req and mem_req in the same IDLE cycle: MEM served first; IF is granted in the IDLE cycle after mem_done.

## Test plan
- Fetch: RAM[0x100..0x103] = 13 05 00 00, if_req addr 0x100 -> ram_a 0x100..0x103 in cycles 1-4, if_done in cycle 6 with if_data 0x00000513.
- Store byte/half/word: mem_wr_en=1, addr 0x20, len 01, wdata 0xAABBCCDD -> ram_wr high exactly 2 cycles, writing 0xDD@0x20 and 0xCC@0x21; mem_done in cycle 3.
- Simultaneous if_req/mem_req: load len 00 from 0x30000 with input byte 0x41 -> mem_done with mem_rdata 0x00000041, then the fetch starts; the IO address is read exactly once.
- rdy low for 3 cycles mid-way through a 4-byte store to 0x30000 region -> each byte written once (ram_wr never asserted while rdy=0), done 3 cycles late.
- if_flush in cycle 3 of a fetch -> no if_done, IDLE in cycle 4; a new if_req at 0x200 in cycle 4 completes normally with correct data.
- rst asserted during WRITE beat 1 -> ram_wr 0 the next cycle, all outputs at reset values, no done pulse.
